if_fetch_unit: RTL and testbench

//  Instruction-fetch stage: producer of pc/instruction/prediction for IF_ID, which feeds the decode stage.

---
 rtl/if_fetch_unit_pkg.sv | 23 ++
 rtl/if_fetch_unit_bht_2bit.sv | 47 ++++
 rtl/if_fetch_unit.sv | 152 +++++++++++++++
 tb/tb_if_fetch_unit.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared opcodes, FSM state codes and immediate decoders for the instruction-fetch stage.
package if_fetch_unit_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [1:0] BHT_INIT  = 2'b01;

  typedef enum logic {
    IF_FETCH = 1'b0,
    IF_HOLD  = 1'b1
  } if_state_t;

  // J-type immediate from inst[31:12]
  function automatic logic [31:0] j_imm(input logic [19:0] hi);
    return {{12{hi[19]}}, hi[7:0], hi[8], hi[18:9], 1'b0};
  endfunction

  // B-type immediate from inst[31:25] and inst[11:7]
  function automatic logic [31:0] b_imm(input logic [6:0] hi, input logic [4:0] lo);
    return {{20{hi[6]}}, lo[0], hi[5:0], lo[4:1], 1'b0};
  endfunction

endpackage

// File: rtl/if_fetch_unit_bht_2bit.sv
// Branch history table: 2^BHT_BITS saturating 2-bit counters, one combinational
// read port and one training port; a same-cycle read returns the pre-update value.
module bht_2bit
  import if_fetch_unit_pkg::*;
#(
  parameter int BHT_BITS = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BHT_BITS-1:0] rd_idx,
  output logic [1:0]          rd_ctr,
  input  logic                upd_en,
  input  logic [BHT_BITS-1:0] upd_idx,
  input  logic                upd_taken
);

  localparam int ENTRIES = 1 << BHT_BITS;

  logic [1:0] ctr_arr [ENTRIES];

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic [1:0] ctr_reg;
      logic       hit;

      assign hit = upd_en && (upd_idx == BHT_BITS'(gi));

      always_ff @(posedge clk) begin
        if (!rst) begin
          ctr_reg <= BHT_INIT;
        end else if (hit) begin
          if (upd_taken && ctr_reg != 2'b11) begin
            ctr_reg <= ctr_reg + 2'b01;
          end else if (!upd_taken && ctr_reg != 2'b00) begin
            ctr_reg <= ctr_reg - 2'b01;
          end
        end
      end

      assign ctr_arr[gi] = ctr_reg;
    end
  endgenerate

  assign rd_ctr = ctr_arr[rd_idx];

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: assembles each 32-bit instruction from four byte reads on a
// shared memory port, predecodes JAL/branches against a BHT and holds it for IF_ID.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int          BHT_BITS = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_in,
  input  logic        br_flag,
  input  logic [31:0] br_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        mem_busy,
  input  logic [7:0]  mem_din,
  output logic        mem_rd_req,
  output logic [31:0] mem_addr,
  output logic        valid_out,
  output logic [31:0] pc_out,
  output logic [31:0] inst_out,
  output logic        pred_out
);

  if_state_t   state_reg;
  logic [31:0] pc_reg;
  logic [2:0]  issue_cnt_reg;
  logic [2:0]  recv_cnt_reg;
  logic        pending_reg;
  logic [31:0] inst_reg;
  logic [31:0] next_pc_reg;
  logic        valid_reg;
  logic [31:0] pc_out_reg;
  logic [31:0] inst_out_reg;
  logic        pred_reg;

  logic        issue_go;
  logic        capture;
  logic        last_byte;
  logic [31:0] inst_next;
  logic [31:0] target_next;
  logic        pred_next;
  logic [1:0]  bht_ctr;
  logic        unused_upd_bits;

  // Requests are suppressed while reset is asserted so the port is quiet during reset.
  assign issue_go   = rst && (state_reg == IF_FETCH) && (issue_cnt_reg < 3'd4) && !mem_busy;
  assign capture    = (state_reg == IF_FETCH) && pending_reg;
  assign last_byte  = capture && (recv_cnt_reg == 3'd3);

  assign mem_rd_req = issue_go;
  assign mem_addr   = issue_go ? (pc_reg + {29'b0, issue_cnt_reg}) : 32'h0;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign inst_next[8*gi +: 8] = (capture && recv_cnt_reg == 3'(gi)) ? mem_din
                                                                         : inst_reg[8*gi +: 8];
    end
  endgenerate

  bht_2bit #(
    .BHT_BITS (BHT_BITS)
  ) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (pc_reg[BHT_BITS+1:2]),
    .rd_ctr    (bht_ctr),
    .upd_en    (upd_valid),
    .upd_idx   (upd_pc[BHT_BITS+1:2]),
    .upd_taken (upd_taken)
  );

  assign unused_upd_bits = ^{upd_pc[31:BHT_BITS+2], upd_pc[1:0]};

  // Predecode on the word as it completes, so the prediction is frozen at HOLD entry.
  always_comb begin
    pred_next   = 1'b0;
    target_next = pc_reg + 32'd4;
    if (inst_next[6:0] == OP_JAL) begin
      pred_next   = 1'b1;
      target_next = pc_reg + j_imm(inst_next[31:12]);
    end else if (inst_next[6:0] == OP_BRANCH && bht_ctr[1]) begin
      pred_next   = 1'b1;
      target_next = pc_reg + b_imm(inst_next[31:25], inst_next[11:7]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IF_FETCH;
      pc_reg        <= RESET_PC;
      issue_cnt_reg <= 3'd0;
      recv_cnt_reg  <= 3'd0;
      pending_reg   <= 1'b0;
      inst_reg      <= 32'h0;
      next_pc_reg   <= 32'h0;
      valid_reg     <= 1'b0;
      pc_out_reg    <= 32'h0;
      inst_out_reg  <= 32'h0;
      pred_reg      <= 1'b0;
    end else if (br_flag) begin
      // Redirect drops any byte still in flight by clearing pending.
      state_reg     <= IF_FETCH;
      pc_reg        <= br_target;
      issue_cnt_reg <= 3'd0;
      recv_cnt_reg  <= 3'd0;
      pending_reg   <= 1'b0;
      valid_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IF_FETCH: begin
          pending_reg <= issue_go;
          if (issue_go) begin
            issue_cnt_reg <= issue_cnt_reg + 3'd1;
          end
          if (capture) begin
            inst_reg     <= inst_next;
            recv_cnt_reg <= recv_cnt_reg + 3'd1;
          end
          if (last_byte) begin
            state_reg    <= IF_HOLD;
            valid_reg    <= 1'b1;
            pc_out_reg   <= pc_reg;
            inst_out_reg <= inst_next;
            pred_reg     <= pred_next;
            next_pc_reg  <= target_next;
          end
        end
        IF_HOLD: begin
          if (!stall_in) begin
            state_reg     <= IF_FETCH;
            pc_reg        <= next_pc_reg;
            issue_cnt_reg <= 3'd0;
            recv_cnt_reg  <= 3'd0;
            pending_reg   <= 1'b0;
            valid_reg     <= 1'b0;
          end
        end
        default: state_reg <= IF_FETCH;
      endcase
    end
  end

  assign valid_out = valid_reg;
  assign pc_out    = pc_out_reg;
  assign inst_out  = inst_out_reg;
  assign pred_out  = pred_reg;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios plus random traffic, compared every
// cycle against a transaction-level fetch model with a byte-addressed memory.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall_in, br_flag, upd_valid, upd_taken, mem_busy;
  logic [31:0] br_target, upd_pc;
  logic [7:0]  mem_din;
  logic        mem_rd_req, valid_out, pred_out;
  logic [31:0] mem_addr, pc_out, inst_out;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(32'h0), .BHT_BITS(6)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .br_flag(br_flag), .br_target(br_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .mem_busy(mem_busy),
    .mem_din(mem_din), .mem_rd_req(mem_rd_req), .mem_addr(mem_addr), .valid_out(valid_out),
    .pc_out(pc_out), .inst_out(inst_out), .pred_out(pred_out)
  );

  int checks = 0;
  int errors = 0;
  logic [7:0] mem [4096];

  // stimulus for the next cycle
  logic        rst_v, stall_v, br_v, upd_v, upd_tk_v, busy_v;
  logic [31:0] br_tgt_v, upd_pc_v;
  // DUT samples
  logic        s_req, s_valid, s_pred;
  logic [31:0] s_addr, s_pc, s_inst;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = 32'h0;
  logic [7:0]  d_din;
  // model
  bit          m_known = 0, m_hold = 0, m_pend = 0;
  int          m_iss = 0, m_rcv = 0;
  logic [31:0] m_pc, m_next, e_pc, e_inst;
  bit          e_pred;
  logic [7:0]  m_bytes [4];
  int          bht [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void predict(input logic [31:0] pc, input logic [31:0] w,
                                  output bit p, output logic [31:0] npc);
    int op, imm;
    op  = int'(w & 32'h7f);
    p   = 0;
    npc = pc + 32'd4;
    if (op == 'h6f) begin
      imm = int'((w >> 31) & 32'h1) * (1 << 20) + int'((w >> 12) & 32'hff) * (1 << 12)
          + int'((w >> 20) & 32'h1) * (1 << 11) + int'((w >> 21) & 32'h3ff) * 2;
      if (imm >= (1 << 20)) imm -= (1 << 21);
      p   = 1;
      npc = pc + 32'(imm);
    end else if (op == 'h63 && bht[int'((pc >> 2) % 64)] >= 2) begin
      imm = int'((w >> 31) & 32'h1) * 4096 + int'((w >> 7) & 32'h1) * 2048
          + int'((w >> 25) & 32'h3f) * 32 + int'((w >> 8) & 32'hf) * 2;
      if (imm >= 4096) imm -= 8192;
      p   = 1;
      npc = pc + 32'(imm);
    end
  endfunction

  task automatic compare();
    bit er;
    if (!m_known) return;
    er = rst_v && !m_hold && m_iss < 4 && !busy_v;
    chk("mem_rd_req", 32'(s_req), 32'(er));
    if (er) chk("mem_addr", s_addr, m_pc + 32'(m_iss));
    chk("valid_out", 32'(s_valid), 32'(m_hold));
    if (m_hold) begin
      chk("pc_out", s_pc, e_pc);
      chk("inst_out", s_inst, e_inst);
      chk("pred_out", 32'(s_pred), 32'(e_pred));
    end
  endtask

  task automatic model_edge();
    int idx;
    bit req;
    if (!rst_v) begin
      m_known = 1; m_hold = 0; m_pend = 0; m_iss = 0; m_rcv = 0; m_pc = 32'h0;
      for (int i = 0; i < 64; i++) bht[i] = 1;
      return;
    end
    if (br_v) begin
      m_pc = br_tgt_v; m_hold = 0; m_iss = 0; m_rcv = 0; m_pend = 0;
    end else if (!m_hold) begin
      req = m_iss < 4 && !busy_v;
      if (m_pend) begin
        m_bytes[m_rcv] = d_din;
        m_rcv++;
        if (m_rcv == 4) begin
          e_inst = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
          e_pc   = m_pc;
          predict(e_pc, e_inst, e_pred, m_next);
          m_hold = 1;
        end
      end
      m_pend = req;
      if (req) m_iss++;
    end else if (!stall_v) begin
      $display("XFER pc=%h inst=%h pred=%0d next=%h", e_pc, e_inst, e_pred, m_next);
      m_pc = m_next; m_hold = 0; m_iss = 0; m_rcv = 0; m_pend = 0;
    end
    if (upd_v) begin
      idx = int'((upd_pc_v >> 2) % 64);
      if (upd_tk_v) bht[idx] = (bht[idx] == 3) ? 3 : bht[idx] + 1;
      else          bht[idx] = (bht[idx] == 0) ? 0 : bht[idx] - 1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    d_din     = prev_req ? mem[prev_addr[11:0]] : 8'($urandom);
    rst       = rst_v;     stall_in  = stall_v;   br_flag = br_v;   br_target = br_tgt_v;
    upd_valid = upd_v;     upd_pc    = upd_pc_v;  upd_taken = upd_tk_v;
    mem_busy  = busy_v;    mem_din   = d_din;
    #1;
    s_req = mem_rd_req; s_addr = mem_addr; s_valid = valid_out;
    s_pc  = pc_out;     s_inst = inst_out; s_pred  = pred_out;
    compare();
    prev_req  = s_req;
    prev_addr = s_addr;
    @(posedge clk);
    model_edge();
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!s_valid && n < limit);
    if (!s_valid) chk("wait_valid timeout", 32'(s_valid), 32'h1);
  endtask

  task automatic put_word(input int a, input logic [31:0] w);
    for (int k = 0; k < 4; k++) mem[a + k] = 8'(w >> (8 * k));
  endtask

  task automatic set_idle();
    rst_v = 1; stall_v = 0; br_v = 0; br_tgt_v = 32'h0;
    upd_v = 0; upd_pc_v = 32'h0; upd_tk_v = 0; busy_v = 0;
  endtask

  initial begin
    logic [31:0] w, mn;
    bit mp;
    int n;

    for (int a = 0; a < 4096; a += 4) begin
      w = $urandom;
      case ($urandom_range(0, 3))
        0: w = (w & ~32'h7f) | 32'h6f;
        1: w = (w & ~32'h7f) | 32'h63;
        default: ;
      endcase
      put_word(a, w);
    end
    put_word(32'h00, 32'h00000013);
    put_word(32'h04, 32'h00000013);
    put_word(32'h10, 32'h1000006F);
    put_word(32'h20, 32'hFE000CE3);

    // pin the model's immediate decoding
    for (int i = 0; i < 64; i++) bht[i] = 1;
    predict(32'h10, 32'h1000006F, mp, mn);
    chk("model jal target", mn, 32'h110);
    bht[8] = 3;
    predict(32'h20, 32'hFE000CE3, mp, mn);
    chk("model beq target", mn, 32'h18);

    // reset and first fetch
    set_idle();
    rst_v = 0;
    step();
    step();
    rst_v = 1;
    step();
    chk("reset valid_out", 32'(s_valid), 32'h0);
    chk("reset pc_out", s_pc, 32'h0);
    chk("reset inst_out", s_inst, 32'h0);
    chk("reset pred_out", 32'(s_pred), 32'h0);
    chk("c0 mem_addr", s_addr, 32'h0);
    for (int i = 1; i < 4; i++) begin
      step();
      chk("c1-3 mem_addr", s_addr, 32'(i));
    end
    step();
    chk("c4 valid_out", 32'(s_valid), 32'h0);
    step();
    chk("c5 valid_out", 32'(s_valid), 32'h1);
    chk("c5 inst_out", s_inst, 32'h00000013);
    chk("c5 pred_out", 32'(s_pred), 32'h0);
    step();
    chk("next fetch addr", s_addr, 32'h4);

    // mem_busy for two cycles after byte 1
    stall_v = 1;
    step();
    busy_v = 1;
    step();
    chk("busy no req", 32'(s_req), 32'h0);
    step();
    chk("busy no req", 32'(s_req), 32'h0);
    busy_v = 0;
    wait_valid(20, n);
    chk("busy latency", 32'(n), 32'h4);
    chk("busy inst_out", s_inst, 32'h00000013);

    // redirect together with transfer: redirect wins
    stall_v = 0; br_v = 1; br_tgt_v = 32'h10;
    step();
    br_v = 0; stall_v = 1;
    step();
    chk("redirect over transfer", s_addr, 32'h10);

    // JAL
    wait_valid(20, n);
    chk("jal pred_out", 32'(s_pred), 32'h1);
    stall_v = 0;
    step();
    stall_v = 1;
    step();
    chk("jal next addr", s_addr, 32'h110);

    // redirect while byte 2 is issued
    step();
    br_v = 1; br_tgt_v = 32'h20;
    step();
    br_v = 0;
    step();
    chk("redirect addr", s_addr, 32'h20);
    wait_valid(20, n);
    chk("redirect latency", 32'(n), 32'h5);
    chk("beq inst_out", s_inst, 32'hFE000CE3);
    chk("beq cold pred", 32'(s_pred), 32'h0);
    stall_v = 0;
    step();
    stall_v = 1;
    step();
    chk("beq not-taken next", s_addr, 32'h24);

    // train BHT twice then refetch
    br_v = 1; br_tgt_v = 32'h20; upd_v = 1; upd_pc_v = 32'h20; upd_tk_v = 1;
    step();
    br_v = 0;
    step();
    upd_v = 0;
    chk("model bht counter", 32'(bht[8]), 32'h3);
    wait_valid(20, n);
    chk("beq trained pred", 32'(s_pred), 32'h1);

    // stall in HOLD
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall valid", 32'(s_valid), 32'h1);
      chk("stall pc", s_pc, 32'h20);
      chk("stall req", 32'(s_req), 32'h0);
    end
    stall_v = 0;
    step();
    step();
    chk("beq taken next", s_addr, 32'h18);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst_v    = ($urandom_range(0, 399) != 0);
      busy_v   = ($urandom_range(0, 3) == 0);
      stall_v  = ($urandom_range(0, 9) < 3);
      br_v     = ($urandom_range(0, 39) == 0);
      br_tgt_v = ($urandom_range(0, 9) == 0) ? (32'hFFFFFFF8 | 32'($urandom_range(0, 7)))
                                             : (32'($urandom_range(0, 1023)) << 2);
      upd_v    = ($urandom_range(0, 4) == 0);
      upd_pc_v = 32'($urandom_range(0, 63)) << 2;
      upd_tk_v = 1'($urandom_range(0, 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
